// File: rtl/wb_master_arbiter.sv
// Two-requester Wishbone arbiter: round-robin grant, lock hold,
// and a stall watchdog that errors out a hung slave access.
module wb_master_arbiter #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          CLK_I,
  input  logic          nRST_I,
  input  logic          r0_CYC_O,
  input  logic          r0_STB_O,
  input  logic          r0_WE_O,
  input  logic          r0_LOCK_O,
  input  logic [6:4]    r0_ADR_O,
  input  logic [DW-1:0] r0_DAT_O,
  input  logic [0:0]    r0_SEL_O,
  input  logic [2:0]    r0_CTI_O,
  input  logic [1:0]    r0_BTE_O,
  output logic          r0_ACK_I,
  output logic          r0_ERR_I,
  output logic          r0_RTY_I,
  output logic [DW-1:0] r0_DAT_I,
  input  logic          r1_CYC_O,
  input  logic          r1_STB_O,
  input  logic          r1_WE_O,
  input  logic          r1_LOCK_O,
  input  logic [6:4]    r1_ADR_O,
  input  logic [DW-1:0] r1_DAT_O,
  input  logic [0:0]    r1_SEL_O,
  input  logic [2:0]    r1_CTI_O,
  input  logic [1:0]    r1_BTE_O,
  output logic          r1_ACK_I,
  output logic          r1_ERR_I,
  output logic          r1_RTY_I,
  output logic [DW-1:0] r1_DAT_I,
  output logic          CYC_O,
  output logic          STB_O,
  output logic          WE_O,
  output logic          LOCK_O,
  output logic [6:4]    ADR_O,
  output logic [DW-1:0] DAT_O,
  output logic [0:0]    SEL_O,
  output logic [2:0]    CTI_O,
  output logic [1:0]    BTE_O,
  input  logic          ACK_I,
  input  logic          ERR_I,
  input  logic          RTY_I,
  input  logic [DW-1:0] DAT_I,
  output logic [1:0]    gnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1,
    ABORT
  } state_t;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_t     state, state_d;
  logic       last_owner, last_owner_d;
  logic [7:0] wait_cnt;

  logic granted;
  logic own1;
  logic own_cyc;
  logic own_stb;
  logic own_lock;
  logic oth_cyc;
  logic abort_cyc;
  logic resp;
  logic timeout;

  assign granted   = (state == GNT0) || (state == GNT1);
  assign own1      = (state == GNT1);
  assign own_cyc   = own1 ? r1_CYC_O  : r0_CYC_O;
  assign own_stb   = own1 ? r1_STB_O  : r0_STB_O;
  assign own_lock  = own1 ? r1_LOCK_O : r0_LOCK_O;
  assign oth_cyc   = own1 ? r0_CYC_O  : r1_CYC_O;
  assign abort_cyc = last_owner ? r1_CYC_O : r0_CYC_O;
  assign resp      = ACK_I | ERR_I | RTY_I;

  // A real slave response in the same cycle beats the watchdog.
  assign timeout = granted && own_stb && !resp &&
                   (wait_cnt == TO_CNT);

  always_comb begin
    CYC_O    = 1'b0;
    STB_O    = 1'b0;
    WE_O     = 1'b0;
    LOCK_O   = 1'b0;
    ADR_O    = '0;
    DAT_O    = '0;
    SEL_O    = '0;
    CTI_O    = '0;
    BTE_O    = '0;
    r0_ACK_I = 1'b0;
    r0_ERR_I = 1'b0;
    r0_RTY_I = 1'b0;
    r0_DAT_I = '0;
    r1_ACK_I = 1'b0;
    r1_ERR_I = 1'b0;
    r1_RTY_I = 1'b0;
    r1_DAT_I = '0;
    if (granted) begin
      CYC_O  = own_cyc & ~timeout;
      STB_O  = own_stb & ~timeout;
      LOCK_O = own_lock & ~timeout;
      WE_O   = own1 ? r1_WE_O  : r0_WE_O;
      ADR_O  = own1 ? r1_ADR_O : r0_ADR_O;
      DAT_O  = own1 ? r1_DAT_O : r0_DAT_O;
      SEL_O  = own1 ? r1_SEL_O : r0_SEL_O;
      CTI_O  = own1 ? r1_CTI_O : r0_CTI_O;
      BTE_O  = own1 ? r1_BTE_O : r0_BTE_O;
      if (own1) begin
        r1_ACK_I = ACK_I;
        r1_ERR_I = ERR_I | timeout;
        r1_RTY_I = RTY_I;
        r1_DAT_I = DAT_I;
      end else begin
        r0_ACK_I = ACK_I;
        r0_ERR_I = ERR_I | timeout;
        r0_RTY_I = RTY_I;
        r0_DAT_I = DAT_I;
      end
    end
  end

  assign gnt_o = {state == GNT1, state == GNT0};

  always_comb begin
    state_d      = state;
    last_owner_d = last_owner;
    unique case (state)
      IDLE: begin
        if (r0_CYC_O && r1_CYC_O)
          state_d = last_owner ? GNT0 : GNT1;
        else if (r0_CYC_O)
          state_d = GNT0;
        else if (r1_CYC_O)
          state_d = GNT1;
      end
      GNT0, GNT1: begin
        if (timeout) begin
          state_d      = ABORT;
          last_owner_d = own1;
        end else if (!own_cyc && !own_lock) begin
          last_owner_d = own1;
          if (oth_cyc)
            state_d = own1 ? GNT0 : GNT1;
          else
            state_d = IDLE;
        end
      end
      ABORT: begin
        if (!abort_cyc)
          state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_I or negedge nRST_I) begin
    if (!nRST_I) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      wait_cnt   <= '0;
    end else begin
      state      <= state_d;
      last_owner <= last_owner_d;
      if (!STB_O || resp)
        wait_cnt <= '0;
      else
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Bench for wb_master_arbiter: vector table plus hand-built
// burst, lock, watchdog and async-reset sequences.
module tb_wb_master_arbiter;

  localparam int DW = 32;

  logic          CLK_I = 1'b0;
  logic          nRST_I;
  logic          r0_CYC_O, r0_STB_O, r0_WE_O, r0_LOCK_O;
  logic [6:4]    r0_ADR_O;
  logic [DW-1:0] r0_DAT_O;
  logic [0:0]    r0_SEL_O;
  logic [2:0]    r0_CTI_O;
  logic [1:0]    r0_BTE_O;
  logic          r0_ACK_I, r0_ERR_I, r0_RTY_I;
  logic [DW-1:0] r0_DAT_I;
  logic          r1_CYC_O, r1_STB_O, r1_WE_O, r1_LOCK_O;
  logic [6:4]    r1_ADR_O;
  logic [DW-1:0] r1_DAT_O;
  logic [0:0]    r1_SEL_O;
  logic [2:0]    r1_CTI_O;
  logic [1:0]    r1_BTE_O;
  logic          r1_ACK_I, r1_ERR_I, r1_RTY_I;
  logic [DW-1:0] r1_DAT_I;
  logic          CYC_O, STB_O, WE_O, LOCK_O;
  logic [6:4]    ADR_O;
  logic [DW-1:0] DAT_O;
  logic [0:0]    SEL_O;
  logic [2:0]    CTI_O;
  logic [1:0]    BTE_O;
  logic          ACK_I, ERR_I, RTY_I;
  logic [DW-1:0] DAT_I;
  logic [1:0]    gnt_o;

  wb_master_arbiter #(.DW(DW), .TIMEOUT(4)) dut (
    .CLK_I(CLK_I), .nRST_I(nRST_I),
    .r0_CYC_O(r0_CYC_O), .r0_STB_O(r0_STB_O),
    .r0_WE_O(r0_WE_O), .r0_LOCK_O(r0_LOCK_O),
    .r0_ADR_O(r0_ADR_O), .r0_DAT_O(r0_DAT_O),
    .r0_SEL_O(r0_SEL_O), .r0_CTI_O(r0_CTI_O),
    .r0_BTE_O(r0_BTE_O),
    .r0_ACK_I(r0_ACK_I), .r0_ERR_I(r0_ERR_I),
    .r0_RTY_I(r0_RTY_I), .r0_DAT_I(r0_DAT_I),
    .r1_CYC_O(r1_CYC_O), .r1_STB_O(r1_STB_O),
    .r1_WE_O(r1_WE_O), .r1_LOCK_O(r1_LOCK_O),
    .r1_ADR_O(r1_ADR_O), .r1_DAT_O(r1_DAT_O),
    .r1_SEL_O(r1_SEL_O), .r1_CTI_O(r1_CTI_O),
    .r1_BTE_O(r1_BTE_O),
    .r1_ACK_I(r1_ACK_I), .r1_ERR_I(r1_ERR_I),
    .r1_RTY_I(r1_RTY_I), .r1_DAT_I(r1_DAT_I),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
    .LOCK_O(LOCK_O), .ADR_O(ADR_O), .DAT_O(DAT_O),
    .SEL_O(SEL_O), .CTI_O(CTI_O), .BTE_O(BTE_O),
    .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I),
    .DAT_I(DAT_I), .gnt_o(gnt_o)
  );

  always #5 CLK_I = ~CLK_I;

  // Requester control nibble is {cyc, stb, we, lock}.
  localparam logic [3:0] NO = 4'b0000;
  localparam logic [3:0] RD = 4'b1100;
  localparam logic [3:0] WR = 4'b1110;
  localparam logic [3:0] LK = 4'b1101;
  localparam logic [3:0] LO = 4'b0001;
  localparam logic [2:0] NR = 3'b000;
  localparam logic [2:0] AK = 3'b100;
  localparam logic [2:0] ER = 3'b010;
  localparam logic [2:0] RT = 3'b001;

  localparam logic [DW-1:0] D0 = 32'hA5A5_0001;
  localparam logic [DW-1:0] D1 = 32'h5A5A_0002;
  localparam logic [DW-1:0] DS = 32'hDEAD_BEEF;

  typedef struct {
    string      nm;
    logic [3:0] m0;
    logic [3:0] m1;
    logic [2:0] rsp;
    logic [1:0] gnt;
    logic       to;
    logic [2:0] cti1;
  } vec_t;

  typedef logic [116:0] obs_t;

  obs_t exp_q[$];
  vec_t tbl[$];
  vec_t cur;
  vec_t z;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(
    string nm, logic [3:0] m0, logic [3:0] m1,
    logic [2:0] rsp, logic [1:0] gnt,
    logic to = 1'b0, logic [2:0] cti1 = 3'b000
  );
    vec_t v;
    v.nm = nm; v.m0 = m0; v.m1 = m1;
    v.rsp = rsp; v.gnt = gnt; v.to = to;
    v.cti1 = cti1;
    return v;
  endfunction

  // Reference routing: everything follows from the expected owner.
  function automatic obs_t model(vec_t v);
    logic o0, o1;
    logic [3:0] m;
    logic [2:0] rs;
    logic [6:4] adr;
    logic [1:0] bte;
    logic [2:0] cti;
    logic [DW-1:0] dat;
    o0  = (v.gnt == 2'b01);
    o1  = (v.gnt == 2'b10);
    m   = o0 ? v.m0 : (o1 ? v.m1 : 4'b0000);
    adr = o0 ? 3'b101 : (o1 ? 3'b010 : 3'b000);
    bte = o0 ? 2'b10 : (o1 ? 2'b01 : 2'b00);
    cti = o1 ? v.cti1 : 3'b000;
    dat = o0 ? D0 : (o1 ? D1 : '0);
    rs  = {v.rsp[2], v.rsp[1] | v.to, v.rsp[0]};
    return {v.gnt, m[3] & ~v.to, m[2] & ~v.to,
            m[1], m[0] & ~v.to, adr, o0, cti, bte, dat,
            o0 ? rs : 3'b000, o0 ? DS : 32'h0,
            o1 ? rs : 3'b000, o1 ? DS : 32'h0};
  endfunction

  function automatic obs_t observe();
    return {gnt_o, CYC_O, STB_O, WE_O, LOCK_O,
            ADR_O, SEL_O, CTI_O, BTE_O, DAT_O,
            r0_ACK_I, r0_ERR_I, r0_RTY_I, r0_DAT_I,
            r1_ACK_I, r1_ERR_I, r1_RTY_I, r1_DAT_I};
  endfunction

  task automatic drive(vec_t v);
    {r0_CYC_O, r0_STB_O, r0_WE_O, r0_LOCK_O} = v.m0;
    {r1_CYC_O, r1_STB_O, r1_WE_O, r1_LOCK_O} = v.m1;
    {ACK_I, ERR_I, RTY_I} = v.rsp;
    r1_CTI_O = v.cti1;
    cur = v;
  endtask

  task automatic check(string nm);
    obs_t e, g;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = exp_q.pop_front();
      g = observe();
      if (g !== e) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", nm, g, e);
      end
    end
  endtask

  task automatic step(vec_t v);
    @(posedge CLK_I);
    #1;
    drive(v);
    exp_q.push_back(model(v));
    @(negedge CLK_I);
    check(v.nm);
  endtask

  initial begin
    r0_ADR_O = 3'b101; r0_DAT_O = D0;
    r0_SEL_O = 1'b1;   r0_CTI_O = 3'b000;
    r0_BTE_O = 2'b10;
    r1_ADR_O = 3'b010; r1_DAT_O = D1;
    r1_SEL_O = 1'b0;   r1_BTE_O = 2'b01;
    DAT_I    = DS;
    nRST_I   = 1'b0;

    // Outputs stay quiet in reset even with requests and ACK high.
    drive(mk("rst", WR, RD, AK, 2'b00));
    #12;
    exp_q.push_back(model(cur));
    check("reset");
    drive(mk("idle", NO, NO, NR, 2'b00));
    @(negedge CLK_I);
    nRST_I = 1'b1;

    tbl.push_back(mk("idle",      NO, NO, NR, 2'b00));
    tbl.push_back(mk("tie_req",   RD, RD, NR, 2'b00));
    tbl.push_back(mk("tie_g0",    RD, RD, AK, 2'b01));
    tbl.push_back(mk("hand_rel0", NO, RD, NR, 2'b01));
    tbl.push_back(mk("hand_g1",   NO, RD, AK, 2'b10));
    tbl.push_back(mk("rel1",      NO, NO, NR, 2'b10));
    tbl.push_back(mk("idle2",     NO, NO, NR, 2'b00));
    tbl.push_back(mk("w0_req",    WR, NO, NR, 2'b00));
    tbl.push_back(mk("w0_ack",    WR, NO, AK, 2'b01));
    tbl.push_back(mk("w0_rel",    NO, NO, NR, 2'b01));
    tbl.push_back(mk("idle3",     NO, NO, NR, 2'b00));
    tbl.push_back(mk("r1_req",    NO, RD, NR, 2'b00));
    tbl.push_back(mk("r1_err",    NO, RD, ER, 2'b10));
    tbl.push_back(mk("r1_rty",    RD, RD, RT, 2'b10));
    tbl.push_back(mk("r1_rel",    RD, NO, NR, 2'b10));
    tbl.push_back(mk("g0_ack",    RD, NO, AK, 2'b01));
    tbl.push_back(mk("g0_rel",    NO, NO, NR, 2'b01));
    tbl.push_back(mk("idle4",     NO, NO, NR, 2'b00));
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i]);

    // r1 4-beat burst while r0 keeps requesting.
    step(mk("b_req",  RD, RD, NR, 2'b00, 1'b0, 3'b010));
    for (int i = 0; i < 3; i++)
      step(mk("b_beat", RD, RD, AK, 2'b10, 1'b0, 3'b010));
    step(mk("b_last", RD, RD, AK, 2'b10, 1'b0, 3'b111));
    step(mk("b_rel",  RD, NO, NR, 2'b10));
    step(mk("b_g0",   RD, NO, AK, 2'b01));
    step(mk("b_g0rel", NO, NO, NR, 2'b01));

    // r0 holds the bus through a CYC gap with LOCK.
    step(mk("l_req",   LK, NO, NR, 2'b00));
    step(mk("l_ack",   LK, RD, AK, 2'b01));
    step(mk("l_hold",  LO, RD, NR, 2'b01));
    step(mk("l_beat",  LK, RD, AK, 2'b01));
    step(mk("l_rel",   NO, RD, NR, 2'b01));
    step(mk("l_g1",    NO, RD, AK, 2'b10));
    step(mk("l_g1rel", NO, NO, NR, 2'b10));

    // Silent slave: watchdog fires after 4 stalled cycles.
    step(mk("t_req", RD, NO, NR, 2'b00));
    for (int i = 0; i < 4; i++)
      step(mk("t_wait", RD, NO, NR, 2'b01));
    step(mk("t_out",   RD, NO, NR, 2'b01, 1'b1));
    step(mk("t_abort", RD, NO, NR, 2'b00));
    step(mk("t_drop",  NO, RD, NR, 2'b00));
    step(mk("t_r1req", NO, RD, NR, 2'b00));
    step(mk("t_g1",    NO, RD, AK, 2'b10));
    step(mk("t_g1rel", NO, NO, NR, 2'b10));

    // ACK landing on the timeout cycle wins and clears the count.
    step(mk("c_req", RD, NO, NR, 2'b00));
    for (int i = 0; i < 4; i++)
      step(mk("c_wait", RD, NO, NR, 2'b01));
    step(mk("c_ack",   RD, NO, AK, 2'b01));
    step(mk("c_after", RD, NO, NR, 2'b01));
    step(mk("c_rel",   NO, NO, NR, 2'b01));

    // Reset pulse mid-burst, no clock edge in between.
    step(mk("s_req", NO, RD, NR, 2'b00, 1'b0, 3'b010));
    step(mk("s_g1",  NO, RD, NR, 2'b10, 1'b0, 3'b010));
    #2;
    nRST_I = 1'b0;
    #1;
    z = cur;
    z.gnt = 2'b00;
    exp_q.push_back(model(z));
    check("rst_async");
    drive(mk("rst_hold", NO, NO, NR, 2'b00));
    @(negedge CLK_I);
    exp_q.push_back(model(cur));
    check("rst_hold");
    nRST_I = 1'b1;
    step(mk("p_tie",  RD, RD, NR, 2'b00));
    step(mk("p_g0",   RD, RD, AK, 2'b01));
    step(mk("p_rel",  NO, NO, NR, 2'b01));
    step(mk("p_idle", NO, NO, NR, 2'b00));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
